hps_ext_cmdq: RTL and testbench
===============================

Name: hps_ext_cmdq

Overview:
- Parametrised EXT_BUS command endpoint between the HPS io channel and core logic.
- Decodes a contiguous window of command codes: two built-in read commands (status snapshot, pending/drop query) and NUM_SET generic write commands.
- Each write command gets its own argument slot and a valid/ack handshake, so one-shot pulse flags and ad-hoc reset inputs are no longer needed.
- Sits beside the core's control FSMs; replaces hand-coded per-command decode.

Parameters:
- CMD_BASE, 'hF0, first command code; CMD_BASE+0 is GET_STATUS, CMD_BASE+1 is GET_PENDING, CMD_BASE+2+i is SET command i.
- NUM_SET, 6, number of write commands (1..14).
- MAX_ARGS, 4, 16-bit argument words stored per write command (1..8).
- STAT_WORDS, 8, 16-bit status words returned by GET_STATUS (1..30).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- EXT_BUS  inout  36  [15:0] dout driven, [31:16] din, [32] dout_en driven, [33] strobe, [34] enable.
- event_tgl  in  1  toggle; every edge counts one event.
- status_in  in  16*STAT_WORDS  live status; word k is bits [16k+15:16k].
- cmd_valid  out  NUM_SET  slot i holds an unconsumed command.
- cmd_ack  in  NUM_SET  consumer frees slot i (single-cycle pulse).
- cmd_args  out  16*MAX_ARGS*NUM_SET  slot i word j is at offset 16*(i*MAX_ARGS+j).
- cmd_nargs  out  4*NUM_SET  argument words received for slot i, saturated at MAX_ARGS.
- drop_cnt  out  8  saturating count of rejected writes.

Behaviour:
- Reset values: all outputs 0; dout and dout_en 0; event counter, word counter and snapshot 0.
- Event counter: 8-bit register, increments on each edge of event_tgl (event_tgl registered once, then XOR with its previous value). Wraps 255->0.
- Bus FSM states: IDLE, HDR, DATA, COMMIT.
  - IDLE: enable low; dout=0, dout_en=0, word counter=0.
  - HDR: first strobe while enable is high latches the code. dout_en=1 only if the code is in [CMD_BASE, CMD_BASE+1+NUM_SET]. A valid code sets dout={8'd0, event counter} on the next cycle. Go to DATA.
  - DATA: each strobe increments a 5-bit word counter, saturating at 31.
    - GET_STATUS, word 1: snapshot all of status_in and return word 0.
    - GET_STATUS, word k (2..STAT_WORDS): return snapshot word k-1.
    - GET_STATUS beyond STAT_WORDS: return 0.
    - GET_PENDING: word 1 = zero-extended cmd_valid; word 2 = {8'd0, drop_cnt}, and drop_cnt clears on that same cycle.
    - SET i: word j+1 (j < MAX_ARGS) is written to a staging buffer; extra words are ignored.
  - Enable falling: SET commands go to COMMIT for one cycle, everything else returns to IDLE.
- Commit rules:
  - Zero argument words received: no commit, not counted as a drop.
  - Otherwise, if slot i is free, or cmd_ack[i] is asserted this cycle: copy staging into slot i, zero-fill missing words, write cmd_nargs, set cmd_valid[i]=1 on the next edge.
  - Else: slot i is unchanged, drop_cnt increments, saturating at 255.
- cmd_ack[i] while slot i is not committing: cmd_valid[i] clears next cycle; args are held, not cleared.
- Drop clear and drop increment in the same cycle: the result is 1.
- Unknown code: no response, no state change, returns to IDLE on enable low.
- Strobe while enable is low: ignored.
- Reset mid-transaction: the partial command is discarded immediately; the bus is released (dout_en=0).
- Latency: dout is valid 1 cycle after strobe; cmd_valid rises 2 cycles after enable falls.

Decomposition:
- Package hps_ext_pkg: CMD_GET_STATUS/CMD_GET_PENDING offsets, bus bit-position constants, FSM state enum, and helper functions for slot/word bit offsets.
- Sub-module hps_ext_slot: one argument slot with the valid/ack/commit rule; instantiated NUM_SET times by generate.

Test Plan:
- Toggle event_tgl 3 times, then send code 'hF0 -> dout word 0 = 16'h0003; word 1 = status word 0; status_in changed mid-read -> words 2..8 still match the snapshot.
- Send 'hF2 with words 16'h1234, 16'hABCD, then enable low -> cmd_valid[0]=1 two cycles later; args = 1234, ABCD, 0, 0; nargs=2.
- Repeat 'hF2 with cmd_valid[0] still set and no ack -> args unchanged, drop_cnt=1. Then 'hF1 -> word 1 = 16'h0001, word 2 = 16'h0001, drop_cnt=0 afterwards.
- cmd_ack[0] asserted in the exact commit cycle of a new 'hF2 with word 16'h5555 -> cmd_valid[0] stays 1, arg0=16'h5555, drop_cnt unchanged.
- Send 'hF2 with 6 words (MAX_ARGS=4) -> only the first 4 are stored, nargs=4. Send 'hE0 -> dout_en stays 0, no outputs change.
- Assert reset between word 2 and word 3 of a SET -> cmd_valid=0, dout_en=0, drop_cnt=0; the next full transaction commits normally.

Source files
------------

// File: rtl/hps_ext_pkg.sv
// rtl/hps_ext_pkg.sv - shared constants, bus state encoding and offset helpers for hps_ext_cmdq
package hps_ext_pkg;

  // Command offsets relative to CMD_BASE
  localparam int CMD_GET_STATUS  = 0;
  localparam int CMD_GET_PENDING = 1;
  localparam int CMD_SET0        = 2;

  // EXT_BUS bit positions
  localparam int BUS_DOUT_LSB = 0;
  localparam int BUS_DIN_LSB  = 16;
  localparam int BUS_DOUT_EN  = 32;
  localparam int BUS_STROBE   = 33;
  localparam int BUS_ENABLE   = 34;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_DATA   = 2'd2,
    ST_COMMIT = 2'd3
  } bus_state_e;

  // Bit offset of argument word `word` of slot `slot` in the flat cmd_args vector
  function automatic int slot_word_lsb(int slot, int word, int max_args);
    return 16 * (slot * max_args + word);
  endfunction

  // Bit offset of status word `word` in the flat status vector
  function automatic int stat_word_lsb(int word);
    return 16 * word;
  endfunction

endpackage

// File: rtl/hps_ext_slot.sv
// rtl/hps_ext_slot.sv - one write-command argument slot with valid/ack/commit handling
module hps_ext_slot
  import hps_ext_pkg::*;
#(
  parameter int MAX_ARGS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    commit_i,
  input  logic                    ack_i,
  input  logic [16*MAX_ARGS-1:0]  stage_i,
  input  logic [3:0]              nargs_i,
  output logic                    valid_o,
  output logic [16*MAX_ARGS-1:0]  args_o,
  output logic [3:0]              nargs_o,
  output logic                    drop_o
);

  logic                   valid_q, valid_d;
  logic [16*MAX_ARGS-1:0] args_q, args_d;
  logic [3:0]             nargs_q, nargs_d;
  logic                   accept;

  // An ack in the commit cycle frees the slot just in time for the new command
  assign accept = commit_i && (!valid_q || ack_i);
  assign drop_o = commit_i && valid_q && !ack_i;

  // Next-state: load and zero-fill on accept, otherwise ack clears valid but holds args
  always_comb begin
    valid_d = valid_q;
    args_d  = args_q;
    nargs_d = nargs_q;
    if (accept) begin
      valid_d = 1'b1;
      nargs_d = nargs_i;
      for (int j = 0; j < MAX_ARGS; j++) begin
        args_d[slot_word_lsb(0, j, MAX_ARGS) +: 16] =
          (4'(j) < nargs_i) ? stage_i[slot_word_lsb(0, j, MAX_ARGS) +: 16] : 16'd0;
      end
    end else if (ack_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      args_q  <= '0;
      nargs_q <= '0;
    end else begin
      valid_q <= valid_d;
      args_q  <= args_d;
      nargs_q <= nargs_d;
    end
  end

  assign valid_o = valid_q;
  assign args_o  = args_q;
  assign nargs_o = nargs_q;

endmodule

// File: rtl/hps_ext_cmdq.sv
// rtl/hps_ext_cmdq.sv - EXT_BUS command endpoint with status/pending reads and queued write slots
module hps_ext_cmdq
  import hps_ext_pkg::*;
#(
  parameter logic [15:0] CMD_BASE   = 16'hF0,
  parameter int          NUM_SET    = 6,
  parameter int          MAX_ARGS   = 4,
  parameter int          STAT_WORDS = 8
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  inout  wire  [35:0]                     EXT_BUS,
  input  logic                            event_tgl,
  input  logic [16*STAT_WORDS-1:0]        status_in,
  output logic [NUM_SET-1:0]              cmd_valid,
  input  logic [NUM_SET-1:0]              cmd_ack,
  output logic [16*MAX_ARGS*NUM_SET-1:0]  cmd_args,
  output logic [4*NUM_SET-1:0]            cmd_nargs,
  output logic [7:0]                      drop_cnt
);

  logic [15:0] bus_din;
  logic        bus_strobe, bus_enable;
  logic        unused_bus;

  assign bus_din    = EXT_BUS[BUS_DIN_LSB +: 16];
  assign bus_strobe = EXT_BUS[BUS_STROBE];
  assign bus_enable = EXT_BUS[BUS_ENABLE];
  assign unused_bus = ^EXT_BUS;

  bus_state_e              state_q, state_d;
  logic                    code_ok_q, code_ok_d;
  logic [3:0]              cmd_off_q, cmd_off_d;
  logic [4:0]              wcnt_q, wcnt_d, wnext;
  logic [15:0]             dout_q, dout_d;
  logic                    dout_en_q, dout_en_d;
  logic [16*STAT_WORDS-1:0] snap_q, snap_d;
  logic [16*MAX_ARGS-1:0]  stage_q, stage_d;
  logic [7:0]              drop_q, drop_d;
  logic [7:0]              ev_cnt_q;
  logic                    tgl_s1_q, tgl_s2_q;
  logic                    drop_clr, drop_inc, in_range, is_set;
  logic [3:0]              nargs_c;
  logic [NUM_SET-1:0]      slot_drop;

  assign EXT_BUS[BUS_DOUT_LSB +: 16] = dout_q;
  assign EXT_BUS[BUS_DOUT_EN]        = dout_en_q;

  assign in_range = (bus_din >= CMD_BASE) && (bus_din <= CMD_BASE + 16'(NUM_SET + 1));
  assign is_set   = code_ok_q && (cmd_off_q >= 4'(CMD_SET0));
  assign wnext    = (wcnt_q == 5'd31) ? 5'd31 : wcnt_q + 5'd1;
  assign nargs_c  = (wcnt_q > 5'(MAX_ARGS)) ? 4'(MAX_ARGS) : wcnt_q[3:0];
  assign drop_inc = |slot_drop;

  // Bus protocol: header decode, per-word read data / write staging, commit on enable fall
  always_comb begin
    state_d   = state_q;
    code_ok_d = code_ok_q;
    cmd_off_d = cmd_off_q;
    wcnt_d    = wcnt_q;
    dout_d    = dout_q;
    dout_en_d = dout_en_q;
    snap_d    = snap_q;
    stage_d   = stage_q;
    drop_clr  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HDR: begin
        wcnt_d = '0;
        if (!bus_enable) begin
          state_d   = ST_IDLE;
          dout_d    = '0;
          dout_en_d = 1'b0;
        end else begin
          state_d = ST_HDR;
          if (bus_strobe) begin
            code_ok_d = in_range;
            cmd_off_d = 4'(bus_din - CMD_BASE);
            dout_en_d = in_range;
            if (in_range) dout_d = {8'd0, ev_cnt_q};
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (!bus_enable) begin
          state_d   = is_set ? ST_COMMIT : ST_IDLE;
          dout_d    = '0;
          dout_en_d = 1'b0;
        end else if (bus_strobe) begin
          wcnt_d = wnext;
          if (code_ok_q) begin
            if (cmd_off_q == 4'(CMD_GET_STATUS)) begin
              dout_d = '0;
              if (wnext == 5'd1) begin
                snap_d = status_in;
                dout_d = status_in[15:0];
              end
              for (int w = 1; w < STAT_WORDS; w++) begin
                if (wnext == 5'(w + 1)) dout_d = snap_q[stat_word_lsb(w) +: 16];
              end
            end else if (cmd_off_q == 4'(CMD_GET_PENDING)) begin
              dout_d = '0;
              if (wnext == 5'd1) begin
                dout_d[NUM_SET-1:0] = cmd_valid;
              end else if (wnext == 5'd2) begin
                dout_d[7:0] = drop_q;
                drop_clr    = 1'b1;
              end
            end else begin
              for (int j = 0; j < MAX_ARGS; j++) begin
                if (wnext == 5'(j + 1)) stage_d[slot_word_lsb(0, j, MAX_ARGS) +: 16] = bus_din;
              end
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // Drop counter: a clear wins over the old count but keeps a same-cycle drop
  always_comb begin
    drop_d = drop_q;
    if (drop_clr) drop_d = {7'd0, drop_inc};
    else if (drop_inc && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Bus state, data and event-counter registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      code_ok_q <= 1'b0;
      cmd_off_q <= '0;
      wcnt_q    <= '0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      snap_q    <= '0;
      stage_q   <= '0;
      drop_q    <= '0;
      ev_cnt_q  <= '0;
      tgl_s1_q  <= 1'b0;
      tgl_s2_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_ok_q <= code_ok_d;
      cmd_off_q <= cmd_off_d;
      wcnt_q    <= wcnt_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      snap_q    <= snap_d;
      stage_q   <= stage_d;
      drop_q    <= drop_d;
      tgl_s1_q  <= event_tgl;
      tgl_s2_q  <= tgl_s1_q;
      if (tgl_s1_q ^ tgl_s2_q) ev_cnt_q <= ev_cnt_q + 8'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SET; gi++) begin : g_slot
      hps_ext_slot #(.MAX_ARGS(MAX_ARGS)) u_slot (
        .clk_i    (clk_sys),
        .rst_i    (reset),
        .commit_i ((state_q == ST_COMMIT) && (wcnt_q != 5'd0) && (cmd_off_q == 4'(CMD_SET0 + gi))),
        .ack_i    (cmd_ack[gi]),
        .stage_i  (stage_q),
        .nargs_i  (nargs_c),
        .valid_o  (cmd_valid[gi]),
        .args_o   (cmd_args[slot_word_lsb(gi, 0, MAX_ARGS) +: 16*MAX_ARGS]),
        .nargs_o  (cmd_nargs[4*gi +: 4]),
        .drop_o   (slot_drop[gi])
      );
    end
  endgenerate

  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_hps_ext_cmdq.sv
// tb/tb_hps_ext_cmdq.sv - self-checking bench for hps_ext_cmdq against a transaction-level model
module tb_hps_ext_cmdq;

  localparam logic [15:0] CMD_BASE = 16'hF0;
  localparam int NUM_SET    = 6;
  localparam int MAX_ARGS   = 4;
  localparam int STAT_WORDS = 8;
  localparam int NA         = 16 * MAX_ARGS * NUM_SET;

  logic                     clk_sys = 1'b0;
  logic                     reset;
  logic                     event_tgl;
  logic [16*STAT_WORDS-1:0] status_in;
  logic [NUM_SET-1:0]       cmd_valid;
  logic [NUM_SET-1:0]       cmd_ack;
  logic [NA-1:0]            cmd_args;
  logic [4*NUM_SET-1:0]     cmd_nargs;
  logic [7:0]               drop_cnt;

  wire  [35:0] ext_bus;
  logic [15:0] din;
  logic        strobe, enable;
  wire  [15:0] dout    = ext_bus[15:0];
  wire         dout_en = ext_bus[32];

  assign ext_bus[31:16] = din;
  assign ext_bus[33]    = strobe;
  assign ext_bus[34]    = enable;
  assign ext_bus[35]    = 1'b0;

  hps_ext_cmdq #(
    .CMD_BASE(CMD_BASE), .NUM_SET(NUM_SET), .MAX_ARGS(MAX_ARGS), .STAT_WORDS(STAT_WORDS)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .EXT_BUS   (ext_bus),
    .event_tgl (event_tgl),
    .status_in (status_in),
    .cmd_valid (cmd_valid),
    .cmd_ack   (cmd_ack),
    .cmd_args  (cmd_args),
    .cmd_nargs (cmd_nargs),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  // Transaction-level reference model
  logic [15:0] m_args [NUM_SET][MAX_ARGS];
  int          m_nargs [NUM_SET];
  bit          m_valid [NUM_SET];
  int          m_drop;
  int          m_events;

  function automatic void m_reset();
    for (int s = 0; s < NUM_SET; s++) begin
      m_valid[s] = 0;
      m_nargs[s] = 0;
      for (int j = 0; j < MAX_ARGS; j++) m_args[s][j] = 16'd0;
    end
    m_drop   = 0;
    m_events = 0;
  endfunction

  function automatic void m_commit(int s, logic [15:0] w[$], bit ack);
    int n;
    if (w.size() == 0) begin
      if (ack) m_valid[s] = 0;
      return;
    end
    if (!m_valid[s] || ack) begin
      n = (w.size() > MAX_ARGS) ? MAX_ARGS : w.size();
      for (int j = 0; j < MAX_ARGS; j++) m_args[s][j] = (j < n) ? w[j] : 16'd0;
      m_nargs[s] = n;
      m_valid[s] = 1;
    end else if (m_drop < 255) begin
      m_drop++;
    end
  endfunction

  function automatic logic [NA-1:0] exp_args();
    logic [NA-1:0] v = '0;
    for (int s = 0; s < NUM_SET; s++)
      for (int j = 0; j < MAX_ARGS; j++) v[16*(s*MAX_ARGS+j) +: 16] = m_args[s][j];
    return v;
  endfunction

  function automatic logic [4*NUM_SET-1:0] exp_nargs();
    logic [4*NUM_SET-1:0] v = '0;
    for (int s = 0; s < NUM_SET; s++) v[4*s +: 4] = 4'(m_nargs[s]);
    return v;
  endfunction

  function automatic logic [NUM_SET-1:0] exp_valid();
    logic [NUM_SET-1:0] v = '0;
    for (int s = 0; s < NUM_SET; s++) v[s] = m_valid[s];
    return v;
  endfunction

  function automatic logic [16*STAT_WORDS-1:0] rand_status();
    logic [16*STAT_WORDS-1:0] v;
    for (int i = 0; i < STAT_WORDS; i++) v[16*i +: 16] = 16'($urandom);
    return v;
  endfunction

  // Stimulus helpers
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_cmd(input logic [15:0] code, output logic [15:0] hdr, output logic hen);
    enable = 1'b1;
    step();
    din    = code;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    hdr    = dout;
    hen    = dout_en;
  endtask

  task automatic xfer(input logic [15:0] w, output logic [15:0] r);
    if ($urandom_range(0, 3) == 0) step();
    din    = w;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    r      = dout;
  endtask

  task automatic send_words(input logic [15:0] w[$]);
    logic [15:0] r;
    foreach (w[i]) xfer(w[i], r);
  endtask

  task automatic end_cmd(input logic [NUM_SET-1:0] ack_at_commit);
    enable = 1'b0;
    step();
    cmd_ack = ack_at_commit;
    step();
    cmd_ack = '0;
    step();
  endtask

  task automatic test_reset();
    if (cmd_valid !== '0) begin errors++; $display("FAIL reset_valid got=%h exp=0", cmd_valid); end
    checks++;
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got=%h exp=0", drop_cnt); end
    checks++;
    if (dout !== 16'd0 || dout_en !== 1'b0) begin
      errors++; $display("FAIL reset_bus got dout=%h en=%b exp 0/0", dout, dout_en);
    end
    checks++;
    if (cmd_args !== '0 || cmd_nargs !== '0) begin
      errors++; $display("FAIL reset_args got args=%h nargs=%h exp 0", cmd_args, cmd_nargs);
    end
    checks++;
  endtask

  task automatic test_status();
    logic [15:0] hdr, r, exp;
    logic hen;
    logic [16*STAT_WORDS-1:0] snap;
    for (int i = 0; i < 3; i++) begin
      event_tgl = ~event_tgl;
      step(); step();
    end
    m_events = (m_events + 3) % 256;
    step(); step(); step();
    status_in = rand_status();
    start_cmd(CMD_BASE, hdr, hen);
    if (hdr !== 16'(m_events) || hen !== 1'b1) begin
      errors++; $display("FAIL status_hdr got=%h en=%b exp=%h en=1", hdr, hen, 16'(m_events));
    end
    checks++;
    snap = status_in;
    xfer(16'($urandom), r);
    if (r !== snap[15:0]) begin errors++; $display("FAIL status_w1 got=%h exp=%h", r, snap[15:0]); end
    checks++;
    status_in = rand_status();
    for (int k = 2; k <= STAT_WORDS + 2; k++) begin
      xfer(16'($urandom), r);
      exp = (k <= STAT_WORDS) ? snap[16*(k-1) +: 16] : 16'd0;
      if (r !== exp) begin errors++; $display("FAIL status_w%0d got=%h exp=%h", k, r, exp); end
      checks++;
    end
    end_cmd('0);
  endtask

  task automatic test_set();
    logic [15:0] hdr;
    logic hen;
    logic [15:0] w[$];
    w = '{16'h1234, 16'hABCD};
    start_cmd(CMD_BASE + 16'd2, hdr, hen);
    if (hen !== 1'b1) begin errors++; $display("FAIL set_hdr_en got=%b exp=1", hen); end
    checks++;
    send_words(w);
    enable = 1'b0;
    step();
    if (cmd_valid[0] !== 1'b0) begin errors++; $display("FAIL set_early_valid got=%b exp=0", cmd_valid[0]); end
    checks++;
    step();
    m_commit(0, w, 1'b0);
    if (cmd_valid !== exp_valid()) begin errors++; $display("FAIL set_valid got=%h exp=%h", cmd_valid, exp_valid()); end
    checks++;
    if (cmd_args !== exp_args()) begin errors++; $display("FAIL set_args got=%h exp=%h", cmd_args, exp_args()); end
    checks++;
    if (cmd_nargs !== exp_nargs()) begin errors++; $display("FAIL set_nargs got=%h exp=%h", cmd_nargs, exp_nargs()); end
    checks++;
    step();
  endtask

  task automatic test_drop();
    logic [15:0] hdr, r;
    logic hen;
    logic [15:0] w[$];
    w = '{16'($urandom), 16'($urandom)};
    start_cmd(CMD_BASE + 16'd2, hdr, hen);
    send_words(w);
    end_cmd('0);
    m_commit(0, w, 1'b0);
    if (cmd_args !== exp_args()) begin errors++; $display("FAIL drop_args got=%h exp=%h", cmd_args, exp_args()); end
    checks++;
    if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL drop_cnt got=%0d exp=%0d", drop_cnt, m_drop); end
    checks++;
    start_cmd(CMD_BASE + 16'd1, hdr, hen);
    xfer(16'd0, r);
    if (r !== 16'(exp_valid())) begin errors++; $display("FAIL pend_w1 got=%h exp=%h", r, 16'(exp_valid())); end
    checks++;
    xfer(16'd0, r);
    if (r !== 16'(m_drop)) begin errors++; $display("FAIL pend_w2 got=%h exp=%h", r, 16'(m_drop)); end
    checks++;
    m_drop = 0;
    end_cmd('0);
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL pend_clear got=%0d exp=0", drop_cnt); end
    checks++;
  endtask

  task automatic test_ack_commit();
    logic [15:0] hdr;
    logic hen;
    logic [15:0] w[$];
    w = '{16'h5555};
    start_cmd(CMD_BASE + 16'd2, hdr, hen);
    send_words(w);
    end_cmd(NUM_SET'(1));
    m_commit(0, w, 1'b1);
    if (cmd_valid !== exp_valid()) begin errors++; $display("FAIL ackc_valid got=%h exp=%h", cmd_valid, exp_valid()); end
    checks++;
    if (cmd_args !== exp_args() || cmd_nargs !== exp_nargs()) begin
      errors++; $display("FAIL ackc_args got=%h/%h exp=%h/%h", cmd_args, cmd_nargs, exp_args(), exp_nargs());
    end
    checks++;
    if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL ackc_drop got=%0d exp=%0d", drop_cnt, m_drop); end
    checks++;
  endtask

  task automatic test_overflow();
    logic [15:0] hdr;
    logic hen;
    logic [15:0] w[$];
    cmd_ack = NUM_SET'(1);
    step();
    cmd_ack = '0;
    m_valid[0] = 0;
    if (cmd_valid !== exp_valid() || cmd_args !== exp_args()) begin
      errors++; $display("FAIL ack_hold got=%h/%h exp=%h/%h", cmd_valid, cmd_args, exp_valid(), exp_args());
    end
    checks++;
    w = {};
    for (int i = 0; i < 6; i++) w.push_back(16'($urandom));
    start_cmd(CMD_BASE + 16'd2, hdr, hen);
    send_words(w);
    end_cmd('0);
    m_commit(0, w, 1'b0);
    if (cmd_args !== exp_args() || cmd_nargs !== exp_nargs() || cmd_valid !== exp_valid()) begin
      errors++; $display("FAIL ovf_args got=%h/%h exp=%h/%h", cmd_args, cmd_nargs, exp_args(), exp_nargs());
    end
    checks++;
  endtask

  task automatic test_unknown();
    logic [15:0] hdr, r;
    logic hen;
    logic [15:0] codes [2];
    codes[0] = 16'h00E0;
    codes[1] = CMD_BASE + 16'(NUM_SET + 2);
    foreach (codes[c]) begin
      start_cmd(codes[c], hdr, hen);
      if (hen !== 1'b0) begin errors++; $display("FAIL unk_hdr_en code=%h got=%b exp=0", codes[c], hen); end
      checks++;
      for (int i = 0; i < 2; i++) begin
        xfer(16'($urandom), r);
        if (dout_en !== 1'b0 || r !== 16'd0) begin
          errors++; $display("FAIL unk_word got dout=%h en=%b exp 0/0", r, dout_en);
        end
        checks++;
      end
      end_cmd('0);
    end
    din    = CMD_BASE + 16'd2;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    step();
    if (dout_en !== 1'b0) begin errors++; $display("FAIL strobe_noen got=%b exp=0", dout_en); end
    checks++;
    if (cmd_valid !== exp_valid() || cmd_args !== exp_args() || drop_cnt !== 8'(m_drop)) begin
      errors++; $display("FAIL unk_state got=%h/%h exp=%h/%h", cmd_valid, drop_cnt, exp_valid(), 8'(m_drop));
    end
    checks++;
  endtask

  task automatic test_random();
    logic [15:0] hdr, r;
    logic hen;
    logic [15:0] w[$];
    logic [NUM_SET-1:0] mask;
    for (int it = 0; it < 24; it++) begin
      int s, n;
      bit ack;
      s   = $urandom_range(0, NUM_SET - 1);
      n   = $urandom_range(0, 6);
      ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        mask    = NUM_SET'($urandom);
        cmd_ack = mask;
        step();
        cmd_ack = '0;
        for (int k = 0; k < NUM_SET; k++) if (mask[k]) m_valid[k] = 0;
      end
      if ($urandom_range(0, 1) == 0) begin
        event_tgl = ~event_tgl;
        m_events  = (m_events + 1) % 256;
        step(); step(); step();
      end
      w = {};
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      start_cmd(CMD_BASE + 16'(2 + s), hdr, hen);
      if (hdr !== 16'(m_events) || hen !== 1'b1) begin
        errors++; $display("FAIL rnd_hdr it=%0d got=%h en=%b exp=%h", it, hdr, hen, 16'(m_events));
      end
      checks++;
      send_words(w);
      end_cmd(ack ? NUM_SET'(1 << s) : '0);
      m_commit(s, w, ack);
      if (cmd_valid !== exp_valid() || cmd_args !== exp_args() || cmd_nargs !== exp_nargs()) begin
        errors++;
        $display("FAIL rnd_slot it=%0d got v=%h n=%h exp v=%h n=%h", it, cmd_valid, cmd_nargs, exp_valid(), exp_nargs());
      end
      checks++;
      if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL rnd_drop it=%0d got=%0d exp=%0d", it, drop_cnt, m_drop); end
      checks++;
      if ($urandom_range(0, 3) == 0) begin
        start_cmd(CMD_BASE + 16'd1, hdr, hen);
        xfer(16'd0, r);
        if (r !== 16'(exp_valid())) begin errors++; $display("FAIL rnd_pend1 got=%h exp=%h", r, 16'(exp_valid())); end
        checks++;
        xfer(16'd0, r);
        if (r !== 16'(m_drop)) begin errors++; $display("FAIL rnd_pend2 got=%h exp=%h", r, 16'(m_drop)); end
        checks++;
        m_drop = 0;
        end_cmd('0);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] hdr, r;
    logic hen;
    logic [15:0] w[$];
    if (event_tgl) begin
      event_tgl = 1'b0;
      step(); step(); step();
    end
    start_cmd(CMD_BASE + 16'd3, hdr, hen);
    xfer(16'($urandom), r);
    xfer(16'($urandom), r);
    reset = 1'b1;
    #1;
    m_reset();
    if (dout_en !== 1'b0 || cmd_valid !== '0 || drop_cnt !== 8'd0 || cmd_args !== '0) begin
      errors++; $display("FAIL rst_mid got en=%b v=%h drop=%h", dout_en, cmd_valid, drop_cnt);
    end
    checks++;
    enable = 1'b0;
    strobe = 1'b0;
    step();
    reset = 1'b0;
    step();
    w = '{16'($urandom), 16'($urandom), 16'($urandom)};
    start_cmd(CMD_BASE + 16'd3, hdr, hen);
    if (hdr !== 16'(m_events) || hen !== 1'b1) begin
      errors++; $display("FAIL rst_hdr got=%h en=%b exp=%h en=1", hdr, hen, 16'(m_events));
    end
    checks++;
    send_words(w);
    end_cmd('0);
    m_commit(1, w, 1'b0);
    if (cmd_valid !== exp_valid() || cmd_args !== exp_args() || cmd_nargs !== exp_nargs()) begin
      errors++; $display("FAIL rst_after got v=%h n=%h exp v=%h n=%h", cmd_valid, cmd_nargs, exp_valid(), exp_nargs());
    end
    checks++;
  endtask

  initial begin
    reset     = 1'b1;
    event_tgl = 1'b0;
    status_in = '0;
    cmd_ack   = '0;
    din       = '0;
    strobe    = 1'b0;
    enable    = 1'b0;
    m_reset();
    step(); step(); step();
    reset = 1'b0;
    step();
    test_reset();
    test_status();
    test_set();
    test_drop();
    test_ack_commit();
    test_overflow();
    test_unknown();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
